// File: rtl/nand_logic_unit_if.sv
// Operand/result bundle for nand_logic_unit: input handshake, operands, op select, output handshake.
// Combinational wiring only; no storage.
// Build option NAND_REDUCE_EN adds the Z_ANY result flag alongside Z.
interface nand_logic_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       OP;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Z;
`ifdef NAND_REDUCE_EN
    logic             Z_ANY;
`endif

    // Operand source and result consumer side.
    modport master (
        output in_valid, A, B, OP, out_ready,
        input  in_ready, out_valid, Z
`ifdef NAND_REDUCE_EN
        , input Z_ANY
`endif
    );

    // Logic unit side.
    modport slave (
        input  in_valid, A, B, OP, out_ready,
        output in_ready, out_valid, Z
`ifdef NAND_REDUCE_EN
        , output Z_ANY
`endif
    );
endinterface

// File: rtl/nand_logic_unit.sv
// WIDTH-bit two-operand logic unit, every function built from 2-input NAND only.
// Latency STAGES cycles, one result per cycle while the consumer is ready.
// Global stall: in_ready = ~out_valid | out_ready; all stages hold while stalled.
// Build option NAND_REDUCE_EN: adds Z_ANY, a NAND-tree OR-reduction of the result.
module nand_logic_unit #(
    parameter int WIDTH  = 8,   // operand/result width, >= 1
    parameter int STAGES = 2    // pipeline depth = latency, 1..4
) (
    input  logic               clk,
    input  logic               rst,
    nand_logic_unit_if.slave   lu
);

    // Function select encodings.
    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_BUFA = 3'd7;

    // ------------------------------------------------------------------
    // NAND primitive and the functions derived from it
    // ------------------------------------------------------------------

    // The one and only gate: n(x,y) = ~(x & y).
    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    // Bitwise application of the primitive across the operand width.
    function automatic logic [WIDTH-1:0] nandv(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = nand2(x[i], y[i]);
        end
        return r;
    endfunction

    // AND: invert the NAND by feeding it to both inputs of another NAND.
    function automatic logic [WIDTH-1:0] andv(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] t;
        t = nandv(x, y);
        return nandv(t, t);
    endfunction

    // OR: De Morgan, NAND of the two self-inverted operands.
    function automatic logic [WIDTH-1:0] orv(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
        return nandv(nandv(x, x), nandv(y, y));
    endfunction

    // XOR: classic four-NAND form sharing the first gate.
    function automatic logic [WIDTH-1:0] xorv(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] t;
        t = nandv(x, y);
        return nandv(nandv(x, t), nandv(y, t));
    endfunction

    // Inverter: NAND with both inputs tied together.
    function automatic logic [WIDTH-1:0] notv(input logic [WIDTH-1:0] x);
        return nandv(x, x);
    endfunction

    // Select one of the eight NAND-built functions.
    function automatic logic [WIDTH-1:0] eval_op(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0]       op);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] t;
        r = '0;
        case (op)
            OP_NAND: r = nandv(a, b);
            OP_AND:  r = andv(a, b);
            OP_OR:   r = orv(a, b);
            OP_NOR: begin
                t = orv(a, b);
                r = nandv(t, t);
            end
            OP_XOR:  r = xorv(a, b);
            OP_XNOR: begin
                t = xorv(a, b);
                r = nandv(t, t);
            end
            OP_NOTA: r = notv(a);
            OP_BUFA: begin
                t = notv(a);
                r = nandv(t, t);
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Input-side evaluation
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] f_res;
    logic             adv;

    // Result is formed combinationally at the input, ahead of the first register.
    always_comb begin
        f_res = eval_op(lu.A, lu.B, lu.OP);
    end

    // Whole pipe moves when the output slot is empty or being drained.
    assign adv         = ~lu.out_valid | lu.out_ready;
    assign lu.in_ready = adv;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];

    // Valid and data shift together on advance; a bubble loads zero data so that
    // Z reads 0 whenever out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d[i] <= '0;
            end
        end else if (adv) begin
            v[0] <= lu.in_valid;
            d[0] <= lu.in_valid ? f_res : '0;
            for (int i = 1; i < STAGES; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
        end
    end

    assign lu.out_valid = v[STAGES-1];
    assign lu.Z         = d[STAGES-1];

`ifdef NAND_REDUCE_EN
    // ------------------------------------------------------------------
    // Optional any-bit-set flag, carried alongside d[]
    // ------------------------------------------------------------------

    // Two-input OR from NANDs, used as the reduction node.
    function automatic logic or2(input logic x, input logic y);
        return nand2(nand2(x, x), nand2(y, y));
    endfunction

    // Balanced OR tree: at each level, node i absorbs node i+stride.
    function automatic logic any_set(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] t;
        t = x;
        for (int s = 1; s < WIDTH; s = s * 2) begin
            for (int i = 0; i + s < WIDTH; i = i + 2 * s) begin
                t[i] = or2(t[i], t[i+s]);
            end
        end
        return t[0];
    endfunction

    logic              any_in;
    logic [STAGES-1:0] r;

    // Reduction computed at the input from the same function result.
    always_comb begin
        any_in = any_set(f_res);
    end

    // Flag pipe mirrors the data pipe: same advance, same bubble clearing, same reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
        end else if (adv) begin
            r[0] <= lu.in_valid & any_in;
            for (int i = 1; i < STAGES; i++) begin
                r[i] <= r[i-1];
            end
        end
    end

    assign lu.Z_ANY = r[STAGES-1];
`endif

endmodule

// File: tb/tb_nand_logic_unit.sv
// Scoreboard bench: 8-bit/2-stage unit with directed vectors, plus 1-bit units at
// every depth 1..4 driven exhaustively. Stimulus pushes expectations; monitors pop
// and compare whenever a result is offered.
module tb_nand_logic_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Main 8-bit, 2-stage unit
    // ------------------------------------------------------------------
    nand_logic_unit_if #(.WIDTH(8)) bus8();
    nand_logic_unit #(.WIDTH(8), .STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .lu  (bus8.slave)
    );

    typedef struct {
        logic [7:0] z;
        logic       any;
        int         cyc;
        bit         lat;
    } exp_t;
    exp_t q8[$];

    // Golden truth table per op, indexed by {a,b}.
    function automatic logic gold1(input logic a, input logic b, input logic [2:0] op);
        logic [3:0] t;
        case (op)
            3'd0: t = 4'b0111;
            3'd1: t = 4'b1000;
            3'd2: t = 4'b1110;
            3'd3: t = 4'b0001;
            3'd4: t = 4'b0110;
            3'd5: t = 4'b1001;
            3'd6: t = 4'b0011;
            default: t = 4'b1100;
        endcase
        return t[{a, b}];
    endfunction

    // Offer one operand set; push the expectation on the cycle it is accepted.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [7:0] ez, input logic eany, input bit lat);
        int w = 0;
        bus8.in_valid = 1'b1;
        bus8.A  = a;
        bus8.B  = b;
        bus8.OP = op;
        @(negedge clk);
        while (!bus8.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus8.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready=%b, required 1 within 50 cycles", bus8.in_ready);
        end else begin
            q8.push_back('{ez, eany, cyc, lat});
        end
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor for the 8-bit unit.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus8.out_valid) begin
                if (q8.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: Z=%h out_valid=1, required no result", bus8.Z);
                end else begin
                    n_cmp++;
                    if (bus8.Z !== q8[0].z) begin
                        n_bad++;
                        $display("FAIL z8: Z=%h, required %h", bus8.Z, q8[0].z);
                    end
`ifdef NAND_REDUCE_EN
                    n_cmp++;
                    if (bus8.Z_ANY !== q8[0].any) begin
                        n_bad++;
                        $display("FAIL z_any: Z_ANY=%b, required %b", bus8.Z_ANY, q8[0].any);
                    end
`endif
                    if (bus8.out_ready) begin
                        if (q8[0].lat) begin
                            n_cmp++;
                            if (cyc - q8[0].cyc != 2) begin
                                n_bad++;
                                $display("FAIL latency8: %0d cycles, required 2", cyc - q8[0].cyc);
                            end
                        end
                        void'(q8.pop_front());
                    end else begin
                        n_cmp++;
                        if (bus8.in_ready !== 1'b0) begin
                            n_bad++;
                            $display("FAIL stall_in_ready: in_ready=%b, required 0", bus8.in_ready);
                        end
                    end
                end
            end else begin
                n_cmp++;
                if (bus8.Z !== 8'h00) begin
                    n_bad++;
                    $display("FAIL z_idle: Z=%h with out_valid=0, required 00", bus8.Z);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // 1-bit units at every depth, shared stimulus
    // ------------------------------------------------------------------
    logic       w1_v;
    logic       w1_a;
    logic       w1_b;
    logic [2:0] w1_op;

    for (genvar g = 1; g <= 4; g++) begin : g_w1
        nand_logic_unit_if #(.WIDTH(1)) b1();
        nand_logic_unit #(.WIDTH(1), .STAGES(g)) u (
            .clk (clk),
            .rst (rst),
            .lu  (b1.slave)
        );
        assign b1.in_valid  = w1_v;
        assign b1.A         = w1_a;
        assign b1.B         = w1_b;
        assign b1.OP        = w1_op;
        assign b1.out_ready = 1'b1;

        logic eq[$];
        int   ec[$];

        // Check offered result first, then record anything accepted this cycle.
        always @(negedge clk) begin
            if (!rst) begin
                if (b1.out_valid) begin
                    n_cmp++;
                    if (eq.size() == 0) begin
                        n_bad++;
                        $display("FAIL w1_unexpected s%0d: Z=%b, required no result", g, b1.Z);
                    end else begin
                        if (b1.Z !== eq[0] || cyc - ec[0] != g) begin
                            n_bad++;
                            $display("FAIL w1_z s%0d: Z=%b after %0d cycles, required %b after %0d",
                                     g, b1.Z, cyc - ec[0], eq[0], g);
                        end
                        void'(eq.pop_front());
                        void'(ec.pop_front());
                    end
                end
                if (b1.in_valid && b1.in_ready) begin
                    eq.push_back(gold1(b1.A, b1.B, b1.OP));
                    ec.push_back(cyc);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst            = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.A         = '0;
        bus8.B         = '0;
        bus8.OP        = '0;
        bus8.out_ready = 1'b1;
        w1_v  = 1'b0;
        w1_a  = 1'b0;
        w1_b  = 1'b0;
        w1_op = '0;

        // Reset state.
        #2;
        n_cmp++;
        if (bus8.out_valid !== 1'b0 || bus8.Z !== 8'h00 || bus8.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: out_valid=%b Z=%h in_ready=%b, required 0 00 1",
                     bus8.out_valid, bus8.Z, bus8.in_ready);
        end
        idle(2);
        rst = 1'b0;
        idle(1);

        // All eight functions back to back on F0/CC.
        send8(8'hF0, 8'hCC, 3'd0, 8'h3F, 1'b1, 1'b1);
        send8(8'hF0, 8'hCC, 3'd1, 8'hC0, 1'b1, 1'b1);
        send8(8'hF0, 8'hCC, 3'd2, 8'hFC, 1'b1, 1'b1);
        send8(8'hF0, 8'hCC, 3'd3, 8'h03, 1'b1, 1'b1);
        send8(8'hF0, 8'hCC, 3'd4, 8'h3C, 1'b1, 1'b1);
        send8(8'hF0, 8'hCC, 3'd5, 8'hC3, 1'b1, 1'b1);
        send8(8'hF0, 8'hCC, 3'd6, 8'h0F, 1'b1, 1'b1);
        send8(8'hF0, 8'hCC, 3'd7, 8'hF0, 1'b1, 1'b1);
        idle(4);

        // Backpressure: four ORs, consumer stalls 3 cycles once a result shows.
        fork
            begin
                send8(8'h01, 8'h02, 3'd2, 8'h03, 1'b1, 1'b0);
                send8(8'h10, 8'h20, 3'd2, 8'h30, 1'b1, 1'b0);
                send8(8'h00, 8'h00, 3'd2, 8'h00, 1'b0, 1'b0);
                send8(8'h81, 8'h18, 3'd2, 8'h99, 1'b1, 1'b0);
            end
            begin
                int w = 0;
                while (!bus8.out_valid && w < 20) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                if (!bus8.out_valid) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL bp_wait: out_valid=%b, required 1 within 20 cycles", bus8.out_valid);
                end
                bus8.out_ready = 1'b0;
                idle(3);
                bus8.out_ready = 1'b1;
            end
        join
        idle(8);

        // Bubble in the middle: valid pattern 1,0,1.
        send8(8'hAA, 8'h55, 3'd0, 8'hFF, 1'b1, 1'b1);
        idle(1);
        send8(8'hAA, 8'h55, 3'd1, 8'h00, 1'b0, 1'b1);
        idle(4);

        // Reduction vectors (Z checked in every build, Z_ANY when present).
        send8(8'h0F, 8'hF0, 3'd1, 8'h00, 1'b0, 1'b1);
        send8(8'h0F, 8'hF0, 3'd2, 8'hFF, 1'b1, 1'b1);
        idle(4);

        // Reset mid-stream with two results in flight.
        send8(8'h12, 8'h34, 3'd4, 8'h26, 1'b1, 1'b1);
        send8(8'h12, 8'h34, 3'd0, 8'hEF, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus8.out_valid !== 1'b0 || bus8.Z !== 8'h00 || bus8.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset: out_valid=%b Z=%h in_ready=%b, required 0 00 1",
                     bus8.out_valid, bus8.Z, bus8.in_ready);
        end
        q8.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);

        // Exhaustive 1-bit sweep across all depths.
        for (int op = 0; op < 8; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                w1_v  = 1'b1;
                w1_op = 3'(op);
                w1_a  = ab[1];
                w1_b  = ab[0];
                idle(1);
            end
        end
        w1_v = 1'b0;
        idle(8);

        // Everything issued must have come out exactly once.
        n_cmp++;
        if (q8.size() != 0 || g_w1[1].eq.size() != 0 || g_w1[2].eq.size() != 0 ||
            g_w1[3].eq.size() != 0 || g_w1[4].eq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: left %0d/%0d/%0d/%0d/%0d, required all 0", q8.size(),
                     g_w1[1].eq.size(), g_w1[2].eq.size(), g_w1[3].eq.size(), g_w1[4].eq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
